// File: rtl/i2c_write_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_write_sequencer
//
// Bit-level sequencer for an I2C master write: START, 8 address bits,
// address ACK, 0..15 data bytes each followed by an ACK slot, then STOP.
// Each bus bit occupies one slot of four quarters, CLK_DIV clk cycles per
// quarter. SCL is low in q0/q1 and high in q2/q3. ACK is sampled on the
// q2->q3 boundary.
//
// Build option: define I2C_SEQ_NACK_RETRY_EN so that the first address NACK
// is answered with STOP, START and a second pass over the address. Only a
// second NACK raises nack_err. Without the macro, an address NACK goes
// straight to STOP and the retry flags are not built.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   start, nbytes    transaction request and data byte count (IDLE only)
//   data_in,
//   data_valid,
//   data_req         data byte handshake (see below)
//   au_go, au_abit   load / shift strobes to the external address shifter
//   au_sda           current address bit from that shifter. It is sampled on
//                    the clock edge that closes the au_abit cycle.
//   scl, sda_o       bus clock and bus data out
//   sda_i            bus data in, used for ACK
//   busy, done,
//   nack_err         status. done is a 1-cycle pulse. nack_err stays set
//                    until the next accepted start.
//   dbg_state        current FSM state
//
// Handshake: the producer holds data_in stable while data_valid=1. A byte
// transfers on the rising edge that closes a cycle with data_req=1.
// data_req asserts only in WAIT_DATA, and only while data_valid=1, so it is
// the ready-and-valid term of the transfer.
// ---------------------------------------------------------------------------
module i2c_write_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nbytes,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_req,
  output logic       au_go,
  output logic       au_abit,
  input  logic       au_sda,
  output logic       scl,
  output logic       sda_o,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, WAIT_DATA, DATA, DATA_ACK, STOP
  } state_t;

  localparam logic [7:0] CYC_MAX = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cyc_q;
  logic [1:0] qtr_q;
  logic [2:0] bit_q;
  logic [3:0] cnt_q;
  logic [7:0] sh_q;
  logic       abit_q, ack_q, nack_q, done_q;
  logic       go, abit, req, fin, nack_set;
`ifdef I2C_SEQ_NACK_RETRY_EN
  logic       tried_q, pend_q, retry_set, retry_clr;
`endif

  logic tick, slot_end, q0_entry, sample, accept;
  assign tick     = (cyc_q == CYC_MAX);
  assign slot_end = tick && (qtr_q == 2'd3);
  assign q0_entry = (cyc_q == 8'd0) && (qtr_q == 2'd0);
  assign sample   = tick && (qtr_q == 2'd2);
  assign accept   = (state_q == IDLE) && start;

  // Next state and single-cycle strobes
  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    abit     = 1'b0;
    req      = 1'b0;
    fin      = 1'b0;
    nack_set = 1'b0;
`ifdef I2C_SEQ_NACK_RETRY_EN
    retry_set = 1'b0;
    retry_clr = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        go      = 1'b1;
      end
      START: if (slot_end) state_d = ADDR;
      ADDR: begin
        abit = q0_entry;
        if (slot_end && bit_q == 3'd7) state_d = ADDR_ACK;
      end
      ADDR_ACK: if (slot_end) begin
        if (!ack_q) begin
          state_d = (cnt_q == 4'd0) ? STOP : WAIT_DATA;
        end else begin
          state_d = STOP;
`ifdef I2C_SEQ_NACK_RETRY_EN
          if (!tried_q) retry_set = 1'b1;
          else          nack_set  = 1'b1;
`else
          nack_set = 1'b1;
`endif
        end
      end
      WAIT_DATA: if (data_valid) begin
        req     = 1'b1;
        state_d = DATA;
      end
      DATA: if (slot_end && bit_q == 3'd7) state_d = DATA_ACK;
      DATA_ACK: if (slot_end) begin
        if (ack_q) begin
          nack_set = 1'b1;
          state_d  = STOP;
        end else begin
          // cnt_q still holds the count including the byte just sent
          state_d = (cnt_q == 4'd1) ? STOP : WAIT_DATA;
        end
      end
      STOP: if (slot_end) begin
`ifdef I2C_SEQ_NACK_RETRY_EN
        if (pend_q) begin
          state_d   = START;
          go        = 1'b1;
          retry_clr = 1'b1;
        end else begin
          state_d = IDLE;
          fin     = 1'b1;
        end
`else
        state_d = IDLE;
        fin     = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= 8'd0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      abit_q  <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef I2C_SEQ_NACK_RETRY_EN
      tried_q <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      // The slot timer is parked at zero while the bus is idle or waiting
      // for data, so every slot starts on a clean q0.
      if (state_q == IDLE || state_q == WAIT_DATA) begin
        cyc_q <= 8'd0;
        qtr_q <= 2'd0;
      end else if (tick) begin
        cyc_q <= 8'd0;
        qtr_q <= qtr_q + 2'd1;
      end else begin
        cyc_q <= cyc_q + 8'd1;
      end
      // Wraps 7 -> 0 at the end of each byte
      if (slot_end && (state_q == ADDR || state_q == DATA)) bit_q <= bit_q + 3'd1;
      if (accept) cnt_q <= nbytes;
      else if (state_q == DATA_ACK && slot_end) cnt_q <= cnt_q - 4'd1;
      if (req) sh_q <= data_in;
      else if (state_q == DATA && slot_end) sh_q <= {sh_q[6:0], 1'b0};
      if (abit) abit_q <= au_sda;
      if (sample && (state_q == ADDR_ACK || state_q == DATA_ACK)) ack_q <= sda_i;
      if (accept) nack_q <= 1'b0;
      else if (nack_set) nack_q <= 1'b1;
      done_q <= fin;
`ifdef I2C_SEQ_NACK_RETRY_EN
      if (accept) begin
        tried_q <= 1'b0;
        pend_q  <= 1'b0;
      end else if (retry_set) begin
        tried_q <= 1'b1;
        pend_q  <= 1'b1;
      end else if (retry_clr) begin
        pend_q  <= 1'b0;
      end
`endif
    end
  end

  // Bus pins. START lowers sda at q2 while scl is high. STOP raises sda
  // together with scl at q2. These are the only mid-slot sda changes.
  always_comb begin
    scl   = 1'b1;
    sda_o = 1'b1;
    case (state_q)
      IDLE:      begin scl = 1'b1;     sda_o = 1'b1;      end
      START:     begin scl = 1'b1;     sda_o = ~qtr_q[1]; end
      ADDR:      begin scl = qtr_q[1]; sda_o = abit_q;    end
      ADDR_ACK:  begin scl = qtr_q[1]; sda_o = 1'b1;      end
      WAIT_DATA: begin scl = 1'b0;     sda_o = 1'b1;      end
      DATA:      begin scl = qtr_q[1]; sda_o = sh_q[7];   end
      DATA_ACK:  begin scl = qtr_q[1]; sda_o = 1'b1;      end
      STOP:      begin scl = qtr_q[1]; sda_o = qtr_q[1];  end
      default:   begin scl = 1'b1;     sda_o = 1'b1;      end
    endcase
  end

  assign data_req  = req;
  assign au_go     = go;
  assign au_abit   = abit;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign nack_err  = nack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_sequencer
//
// Directed and randomized write transactions against i2c_write_sequencer.
// A bus monitor records sda_o at every rising scl edge and counts START/STOP
// conditions and strobes. The expected bit stream is built from the
// transaction description: address MSB-first, ACK release, data bytes, STOP.
// The bench also models the external address shifter. sda_i is driven as
// the slave's ACK/NACK according to the scl edge count.
// ---------------------------------------------------------------------------
module tb_i2c_write_sequencer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nbytes = 4'd0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_req, au_go, au_abit, au_sda;
  logic       scl, sda_o, busy, done, nack_err;
  logic       sda_i = 1'b0;
  logic [2:0] dbg_state;

  i2c_write_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .nbytes(nbytes),
    .data_in(data_in), .data_valid(data_valid), .data_req(data_req),
    .au_go(au_go), .au_abit(au_abit), .au_sda(au_sda),
    .scl(scl), .sda_o(sda_o), .sda_i(sda_i),
    .busy(busy), .done(done), .nack_err(nack_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // External address shifter model: au_go loads, au_abit advances
  logic [7:0] addr_v = 8'h00;
  logic [7:0] ash = 8'hFF;
  always @(posedge clk) begin
    if (au_go)        ash <= addr_v;
    else if (au_abit) ash <= {ash[6:0], 1'b0};
  end
  assign au_sda = ash[7];

  // Bus monitor / slave responder
  logic [0:0] obs_q[$];
  int  go_cnt = 0, abit_cnt = 0, req_cnt = 0, done_cnt = 0, rise_cnt = 0;
  int  st_cnt = 0, sp_cnt = 0, lat = 0, lat_done = 0;
  logic both_err = 1'b0, bad_req = 1'b0;
  logic scl_p = 1'b1, sda_p = 1'b1;
  logic nack_all = 1'b0;
  int   nack_byte = 0;

  always @(negedge clk) begin
    if (au_go && !busy) begin
      obs_q.delete();
      go_cnt = 0; abit_cnt = 0; req_cnt = 0; done_cnt = 0; rise_cnt = 0;
      st_cnt = 0; sp_cnt = 0; lat = 0; lat_done = 0;
    end else begin
      lat++;
    end
    if (au_go) go_cnt++;
    if (au_abit) abit_cnt++;
    if (au_go && au_abit) both_err = 1'b1;
    if (data_req) begin
      req_cnt++;
      if (!data_valid) bad_req = 1'b1;
    end
    if (done) begin
      if (done_cnt == 0) lat_done = lat;
      done_cnt++;
    end
    if (scl && !scl_p) begin
      obs_q.push_back(sda_o);
      rise_cnt++;
    end
    if (scl && scl_p && sda_p && !sda_o) st_cnt++;
    if (scl && !sda_p && sda_o) sp_cnt++;
    scl_p = scl;
    sda_p = sda_o;
    // ACK slot of data byte k is the 9*(k+1)-th rising scl edge
    sda_i = nack_all ? 1'b1 : ((nack_byte != 0) && (rise_cnt == 9 * (nack_byte + 1)));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no end of test, required finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  logic [7:0] d [16];

  function automatic logic [255:0] pack_q(input logic [0:0] q[$]);
    logic [255:0] v;
    v = '0;
    foreach (q[i]) v = {v[254:0], q[i]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver + scoreboard for one full transaction
  task automatic run_txn(input logic [7:0] a, input int nb, input int nk_addr,
                         input int nk_byte, input int wait_first, input int poke);
    logic [0:0] exp_q[$];
    int   exp_go, exp_req, to, dl;
    logic exp_nack, hung, stop_b;
    addr_v    = a;
    nack_all  = (nk_addr != 0);
    nack_byte = nk_byte;
    hung      = 1'b0;
    // Reference bit stream seen at rising scl edges
    exp_go = 1;
    for (int b = 7; b >= 0; b--) exp_q.push_back(a[b]);
    exp_q.push_back(1'b1);
    if (nk_addr != 0) begin
`ifdef I2C_SEQ_NACK_RETRY_EN
      exp_q.push_back(1'b1);
      for (int b = 7; b >= 0; b--) exp_q.push_back(a[b]);
      exp_q.push_back(1'b1);
      exp_go = 2;
`endif
      exp_req = 0;
    end else begin
      exp_req = nb;
      stop_b  = 1'b0;
      for (int k = 1; k <= nb; k++) begin
        if (!stop_b) begin
          for (int b = 7; b >= 0; b--) exp_q.push_back(d[k-1][b]);
          exp_q.push_back(1'b1);
          if (k == nk_byte) begin
            exp_req = k;
            stop_b  = 1'b1;
          end
        end
      end
    end
    exp_q.push_back(1'b1);
    exp_nack = (nk_addr != 0) || (nk_byte != 0);

    @(posedge clk); #1 start = 1'b1; nbytes = 4'(nb);
    @(posedge clk); #1 start = 1'b0; nbytes = 4'($urandom);
    if (poke != 0) begin
      repeat (40) @(posedge clk);
      #1 start = 1'b1; nbytes = 4'hF;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < nb; i++) begin
      dl = (i == 0) ? wait_first : $urandom_range(0, 8);
      repeat (dl) @(posedge clk);
      #1 data_in = d[i]; data_valid = 1'b1;
      to = 0;
      do begin
        @(negedge clk); to++;
      end while (data_req !== 1'b1 && busy === 1'b1 && to < 5000);
      if (to >= 5000) hung = 1'b1;
      if (data_req === 1'b1) begin
        @(posedge clk); #1;
      end
      data_valid = 1'b0;
      data_in = 8'($urandom);
      if (busy !== 1'b1) i = nb;
    end
    to = 0;
    while (done_cnt == 0 && to < 8000) begin
      @(negedge clk); to++;
    end
    if (to >= 8000) hung = 1'b1;
    repeat (4) @(negedge clk);

    chk("no_timeout", 256'(hung), 256'(0));
    chk("seq_len", 256'(obs_q.size()), 256'(exp_q.size()));
    chk("seq_bits", pack_q(obs_q), pack_q(exp_q));
    chk("data_req_cnt", 256'(req_cnt), 256'(exp_req));
    chk("au_go_cnt", 256'(go_cnt), 256'(exp_go));
    chk("au_abit_cnt", 256'(abit_cnt), 256'(8 * exp_go));
    chk("start_conds", 256'(st_cnt), 256'(exp_go));
    chk("stop_conds", 256'(sp_cnt), 256'(exp_go));
    chk("done_cnt", 256'(done_cnt), 256'(1));
    chk("nack_err", 256'(nack_err), 256'(exp_nack));
    chk("busy_idle", 256'(busy), 256'(0));
    chk("go_abit_excl", 256'(both_err), 256'(0));
    chk("req_needs_valid", 256'(bad_req), 256'(0));
    if (nb == 0 && nk_addr == 0) chk("latency", 256'(lat_done), 256'(44 * CLK_DIV + 1));
    nack_all  = 1'b0;
    nack_byte = 0;
  endtask

  initial begin
    int   to, nb, r, nk_a, nk_b;
    logic ok;

    // Reset state
    #2;
    chk("rst_scl", 256'(scl), 256'(1));
    chk("rst_sda", 256'(sda_o), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_nack", 256'(nack_err), 256'(0));
    chk("rst_strobes", 256'({data_req, au_go, au_abit}), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Address-only, ACK: strobe counts and latency
    run_txn(8'hA2, 0, 0, 0, 0, 0);

    // Two data bytes
    d[0] = 8'hA5; d[1] = 8'h3C;
    run_txn(8'h3B, 2, 0, 0, 2, 0);

    // Data withheld for 100 cycles while waiting for the first byte
    d[0] = 8'h96;
    fork
      run_txn(8'h71, 1, 0, 0, 300, 0);
      begin
        repeat (200) @(negedge clk);
        ok = 1'b1;
        repeat (100) begin
          @(negedge clk);
          if (scl !== 1'b0 || data_req !== 1'b0) ok = 1'b0;
        end
        chk("wait_data_hold", 256'(ok), 256'(1));
      end
    join

    // Address NACK
    d[0] = 8'h11;
    run_txn(8'hC4, 1, 1, 0, 0, 0);

    // NACK on the first of two data bytes
    d[0] = 8'hE7; d[1] = 8'h18;
    run_txn(8'h5A, 2, 0, 1, 1, 0);

    // start re-pulsed while busy is ignored
    d[0] = 8'h4D;
    run_txn(8'h29, 1, 0, 0, 3, 1);

    // Reset during the third address bit
    addr_v = 8'hF0;
    @(posedge clk); #1 start = 1'b1; nbytes = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    to = 0;
    while (abit_cnt < 3 && to < 2000) begin
      @(negedge clk); to++;
    end
    chk("abit3_reached", 256'(to >= 2000), 256'(0));
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_scl", 256'(scl), 256'(1));
    chk("midrst_sda", 256'(sda_o), 256'(1));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_out", 256'({done, nack_err, data_req, au_go, au_abit}), 256'(0));
    @(posedge clk); #1 rst = 1'b1;
    d[0] = 8'hC3;
    run_txn(8'h6E, 1, 0, 0, 0, 0);

    // Randomized transactions
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 16; j++) d[j] = 8'($urandom);
      nb = $urandom_range(0, 4);
      r  = $urandom_range(0, 5);
      nk_a = (r == 0) ? 1 : 0;
      nk_b = (r == 1 && nb > 0) ? $urandom_range(1, nb) : 0;
      run_txn(8'($urandom), nb, nk_a, nk_b, $urandom_range(0, 20), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_write_sequencer.md
I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period (legal 2..255).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a transaction request sampled only in IDLE.
REQ-005 The block SHALL have port nbytes, input, 4, the data byte count, sampled with start; 0 means address-only.
REQ-006 The block SHALL have port data_in, input, 8, the next data byte, valid while data_valid=1.
REQ-007 The block SHALL have port data_valid, input, 1, the data-byte handshake valid.
REQ-008 The block SHALL have port data_req, output, 1, the 1-cycle pulse that consumes data_in when data_valid=1.
REQ-009 The block SHALL have ports au_go (output, 1, 1-cycle load strobe), au_abit (output, 1, 1-cycle shift strobe) and au_sda (input, 1, shifted address bit) to sequence the address shifter.
REQ-010 The block SHALL have ports scl, output, 1, the bus clock, and sda_o, output, 1, the bus data.
REQ-011 The block SHALL have port sda_i, input, 1, the sampled bus data, used for ACK.
REQ-012 The block SHALL have ports busy (output, 1), done (output, 1, 1-cycle pulse) and nack_err (output, 1, sticky until next start).

Function
REQ-013 The FSM SHALL have states IDLE, START, ADDR, ADDR_ACK, WAIT_DATA, DATA, DATA_ACK, STOP.
REQ-014 Each bit slot SHALL be 4 quarters of CLK_DIV cycles; scl=0 in q0 and q1, scl=1 in q2 and q3; sda_o changes only at q0 entry.
REQ-015 IDLE with start=1 SHALL go to START, latch nbytes, clear nack_err, assert busy and pulse au_go the same cycle.
REQ-016 START SHALL hold scl=1 and drive sda_o 1 for q0-q1, then 0 for q2-q3 before entering ADDR.
REQ-017 ADDR SHALL run exactly 8 bit slots; at each q0 entry au_abit pulses for 1 cycle, and sda_o takes au_sda one cycle later.
REQ-018 ADDR_ACK SHALL release sda_o=1 for one slot and sample sda_i at the q2->q3 boundary; 0 is ACK and 1 is NACK.
REQ-019 On address ACK, the FSM SHALL go to STOP if the remaining count is 0, else to WAIT_DATA.
REQ-020 WAIT_DATA SHALL hold scl=0; when data_valid=1 it SHALL pulse data_req, load data_in into the shift register and enter DATA. It SHALL wait indefinitely otherwise.
REQ-021 DATA SHALL shift 8 bits MSB-first, then DATA_ACK samples sda_i as in REQ-018 and decrements the remaining count.
REQ-022 On data ACK, the FSM SHALL go to WAIT_DATA if the count is nonzero, else to STOP.
REQ-023 Any NACK SHALL set nack_err and go to STOP, except as modified by REQ-031.
REQ-024 STOP SHALL drive sda_o=0 for q0-q1, then scl=1 with sda_o=1 for q2-q3. It SHALL then pulse done, clear busy and return to IDLE.
REQ-025 Bus latency: an address-only transaction SHALL take exactly 11 slots (44*CLK_DIV cycles) from start to done, plus 1 cycle.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 au_go and au_abit SHALL never be asserted in the same cycle.

Reset
REQ-028 rst=0 SHALL immediately force IDLE with scl=1, sda_o=1, busy=0, done=0, nack_err=0, data_req=0, au_go=0 and au_abit=0; all counters SHALL be 0.
REQ-029 Reset mid-transaction SHALL abort without a STOP; the next start SHALL begin cleanly.

Configuration
REQ-030 The macro I2C_SEQ_NACK_RETRY_EN SHALL select address-NACK retry.
REQ-031 With I2C_SEQ_NACK_RETRY_EN defined, the first address NACK SHALL issue a STOP, then a START (re-pulsing au_go) and repeat the address once. nack_err SHALL be set only if the retry also NACKs.
REQ-032 Without I2C_SEQ_NACK_RETRY_EN, an address NACK SHALL go directly to STOP with nack_err=1; no retry logic SHALL be synthesized.

Verification
REQ-033 Reset mid-ADDR (3rd bit) -> scl=1, sda_o=1, busy=0 within 1 cycle of rst falling.
REQ-034 CLK_DIV=4, nbytes=0, sda_i=0 -> au_go once, exactly 8 au_abit pulses, done pulse 177 cycles after start, nack_err=0.
REQ-035 nbytes=2, data 8'hA5 then 8'h3C, sda_i=0 -> sda_o slot sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; 2 data_req pulses; done=1.
REQ-036 data_valid held 0 for 100 cycles in WAIT_DATA -> scl stays 0, no data_req until data_valid=1.
REQ-037 Address NACK (sda_i=1) -> nack_err=1 and STOP; with I2C_SEQ_NACK_RETRY_EN, 2 au_go pulses and 16 au_abit pulses before STOP.
REQ-038 start pulsed while busy -> ignored; nbytes unchanged; exactly one done pulse.
